// File: rtl/uart_tx_sched_if.sv
// Requester-side valid/ready byte bus shared by the uart_tx_sched requesters.
// Byte of requester i travels on req_data[8i+7:8i].
interface uart_tx_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit path between NREQ byte requesters,
// with packet locking and a busy_tx rise timeout.
module uart_tx_sched #(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned BUSY_TMO = 16,
  localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  uart_tx_sched_if.slave        req_if,
  output logic [7:0]            datatx,
  output logic                  tx_shoot,
  input  logic                  busy_tx,
  output logic [IW-1:0]         grant_id,
  output logic                  locked,
  output logic                  err_tmo,
  input  logic                  err_clr
);

  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHOOT   = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant_id;
  logic [7:0]      r_datatx;
  logic            r_tx_shoot;
  logic            r_locked;
  logic            r_err_tmo;
  logic [CW-1:0]   r_cnt;

  logic [NREQ-1:0]   w_elig;
  logic [2*NREQ-1:0] w_dbl;
  logic [IW-1:0]     w_win;
  logic              w_win_vld;
  logic [7:0]        w_byte;
  logic              w_last;
  logic [NREQ-1:0]   w_ready;
  logic              w_accept;
  logic              w_tmo;
  int                w_off;
  int                w_sum;

  // Winner: first eligible index at or above rr_ptr, found by rotating the eligible mask.
  always_comb begin : win_scan
    w_elig    = '0;
    w_dbl     = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    w_byte    = '0;
    w_last    = 1'b0;
    w_off     = 0;
    w_sum     = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_elig[i] = req_if.req_valid[i] && (!r_locked || (i == int'(r_grant_id)));
    end
    w_dbl     = {w_elig, w_elig} >> r_rr_ptr;
    w_win_vld = |w_dbl[NREQ-1:0];
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (w_dbl[k]) w_off = k;
    end
    w_sum = int'(r_rr_ptr) + w_off;
    if (w_sum >= int'(NREQ)) w_sum = w_sum - int'(NREQ);
    w_win = IW'(w_sum);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (i == w_sum) begin
        w_byte = req_if.req_data[8*i +: 8];
        w_last = req_if.req_last[i];
      end
    end
  end

  // Next state, ready, accept and timeout decode.
  always_comb begin : fsm_comb
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!busy_tx && w_win_vld) begin
          w_ready[w_win] = 1'b1;
          w_accept       = req_if.req_valid[w_win];
          if (w_accept) w_state_nxt = S_SHOOT;
        end
      end
      S_SHOOT:   w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: begin
        if (busy_tx) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_cnt == CW'(BUSY_TMO - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_LO: if (!busy_tx) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin : fsm_reg
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Launch datapath, grant/lock tracking, timeout counter and sticky error.
  always_ff @(posedge pclk or negedge presetn) begin : dp_reg
    if (!presetn) begin
      r_datatx   <= '0;
      r_tx_shoot <= 1'b0;
      r_grant_id <= '0;
      r_locked   <= 1'b0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
      r_err_tmo  <= 1'b0;
    end else begin
      r_tx_shoot <= w_accept;
      if (w_accept) begin
        r_datatx   <= w_byte;
        r_grant_id <= w_win;
        r_locked   <= !w_last;
        if (w_last) r_rr_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
      end
      if (r_state == S_SHOOT)                     r_cnt <= '0;
      else if (r_state == S_WAIT_HI && !busy_tx)  r_cnt <= r_cnt + CW'(1);
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (w_tmo)        r_err_tmo <= 1'b1;
      else if (err_clr) r_err_tmo <= 1'b0;
    end
  end

  assign req_if.req_ready = w_ready;
  assign datatx           = r_datatx;
  assign tx_shoot         = r_tx_shoot;
  assign grant_id         = r_grant_id;
  assign locked           = r_locked;
  assign err_tmo          = r_err_tmo;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a simple busy_tx transmitter model.
module tb_uart_tx_sched;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned BUSY_TMO = 16;
  localparam int unsigned IW       = 2;

  logic            pclk = 1'b0;
  logic            presetn;
  logic            busy_force = 1'b0;
  logic            busy_mdl   = 1'b0;
  logic            busy_tx;
  logic            err_clr;
  logic [7:0]      datatx;
  logic            tx_shoot;
  logic [IW-1:0]   grant_id;
  logic            locked;
  logic            err_tmo;

  int n_chk  = 0;
  int n_fail = 0;
  int n_stall_viol = 0;

  bit mdl_en   = 1'b0;
  int hi_delay = 3;
  int hi_len   = 10;
  int m_cnt    = 0;
  bit m_act    = 1'b0;

  uart_tx_sched_if #(.NREQ(NREQ)) req_if ();

  uart_tx_sched #(.NREQ(NREQ), .BUSY_TMO(BUSY_TMO)) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .req_if   (req_if),
    .datatx   (datatx),
    .tx_shoot (tx_shoot),
    .busy_tx  (busy_tx),
    .grant_id (grant_id),
    .locked   (locked),
    .err_tmo  (err_tmo),
    .err_clr  (err_clr)
  );

  always #5 pclk = ~pclk;

  assign busy_tx = busy_force | busy_mdl;

  // Transmitter model: busy rises hi_delay cycles after the launch and holds hi_len cycles.
  always @(posedge pclk) begin
    #1;
    if (!presetn) begin
      busy_mdl = 1'b0;
      m_act    = 1'b0;
      m_cnt    = 0;
    end else if (mdl_en && tx_shoot) begin
      m_cnt    = 0;
      m_act    = 1'b1;
      busy_mdl = 1'b0;
    end else if (m_act) begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= hi_delay + hi_len) begin
        busy_mdl = 1'b0;
        m_act    = 1'b0;
      end else begin
        busy_mdl = (m_cnt >= hi_delay);
      end
    end
  end

  // Nobody but the locked requester may see req_ready while a packet is open.
  always @(negedge pclk) begin
    if (presetn === 1'b1 && locked === 1'b1 &&
        ((req_if.req_ready & ~(NREQ'(1) << grant_id)) != '0))
      n_stall_viol = n_stall_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic apply_reset();
    presetn           = 1'b0;
    req_if.req_valid  = '0;
    req_if.req_data   = '0;
    req_if.req_last   = '0;
    busy_force        = 1'b0;
    err_clr           = 1'b0;
    mdl_en            = 1'b0;
    hi_delay          = 1;
    hi_len            = 1;
    tick();
    tick();
    presetn = 1'b1;
    tick();
  endtask

  task automatic wait_shoot(input string tag, output bit ok);
    int n;
    n = 0;
    tick();
    while (tx_shoot !== 1'b1 && n < 60) begin
      tick();
      n = n + 1;
    end
    ok = (tx_shoot === 1'b1);
    if (!ok) check({tag, "_shoot_timeout"}, 32'(tx_shoot), 32'd1);
  endtask

  initial begin
    bit ok;
    bit saw_hi;
    bit rdy_seen;
    int t_fall;
    int t_rdy;
    logic [7:0] exp_d [4];
    logic [IW-1:0] exp_g [4];
    logic exp_l [4];

    // Reset values
    presetn          = 1'b0;
    req_if.req_valid = '0;
    req_if.req_data  = '0;
    req_if.req_last  = '0;
    err_clr          = 1'b0;
    tick();
    tick();
    check("rst_datatx",   32'(datatx),           32'd0);
    check("rst_tx_shoot", 32'(tx_shoot),         32'd0);
    check("rst_grant_id", 32'(grant_id),         32'd0);
    check("rst_locked",   32'(locked),           32'd0);
    check("rst_err_tmo",  32'(err_tmo),          32'd0);
    check("rst_req_ready",32'(req_if.req_ready), 32'd0);
    presetn = 1'b1;
    tick();

    // Single byte from req0
    mdl_en   = 1'b1;
    hi_delay = 3;
    hi_len   = 10;
    req_if.req_data[7:0] = 8'hA5;
    req_if.req_last      = 4'b0001;
    req_if.req_valid     = 4'b0001;
    #1;
    check("sb_ready", 32'(req_if.req_ready), 32'h1);
    tick();
    check("sb_shoot",      32'(tx_shoot),         32'd1);
    check("sb_data",       32'(datatx),           32'hA5);
    check("sb_ready_drop", 32'(req_if.req_ready), 32'd0);
    check("sb_locked",     32'(locked),           32'd0);
    saw_hi = 1'b0;
    t_fall = -1;
    t_rdy  = -1;
    for (int k = 1; k <= 40 && t_rdy < 0; k++) begin
      tick();
      if (k == 1) check("sb_shoot_1cyc", 32'(tx_shoot), 32'd0);
      if (busy_tx === 1'b1) saw_hi = 1'b1;
      else if (saw_hi && t_fall < 0) t_fall = k;
      if (req_if.req_ready != '0) t_rdy = k;
    end
    check("sb_next_ready_cyc", t_rdy, 32'd14);
    check("sb_ready_after_fall", t_rdy - t_fall, 32'd1);
    req_if.req_valid = '0;

    // Round-robin fairness
    apply_reset();
    mdl_en = 1'b1;
    req_if.req_data  = {8'h43, 8'h42, 8'h41, 8'h40};
    req_if.req_last  = 4'hF;
    req_if.req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      wait_shoot($sformatf("rr%0d", g), ok);
      if (ok) begin
        check($sformatf("rr_gnt%0d", g),  32'(grant_id), 32'(g % 4));
        check($sformatf("rr_data%0d", g), 32'(datatx),   32'(8'h40 + 8'(g % 4)));
      end
    end
    req_if.req_valid = '0;

    // Packet lock: req1 sends 11/22/33 while req0 and req2 wait
    apply_reset();
    mdl_en = 1'b1;
    req_if.req_data  = 32'h0000_0000;
    req_if.req_last  = 4'b0001;
    req_if.req_valid = 4'b0001;
    wait_shoot("pk_pre", ok);
    req_if.req_valid = '0;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h02};
    exp_g = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_l = '{1'b1, 1'b1, 1'b0, 1'b0};
    n_stall_viol = 0;
    req_if.req_data  = {8'h00, 8'h02, 8'h11, 8'h00};
    req_if.req_last  = 4'b0101;
    req_if.req_valid = 4'b0111;
    for (int p = 0; p < 4; p++) begin
      wait_shoot($sformatf("pk%0d", p), ok);
      if (ok) begin
        check($sformatf("pk_data%0d", p),   32'(datatx),   32'(exp_d[p]));
        check($sformatf("pk_gnt%0d", p),    32'(grant_id), 32'(exp_g[p]));
        check($sformatf("pk_locked%0d", p), 32'(locked),   32'(exp_l[p]));
      end
      if (p == 0) req_if.req_data[15:8] = 8'h22;
      if (p == 1) begin
        req_if.req_data[15:8] = 8'h33;
        req_if.req_last[1]    = 1'b1;
      end
      if (p == 2) req_if.req_valid[1] = 1'b0;
    end
    req_if.req_valid = '0;
    check("pk_no_interleave", n_stall_viol, 32'd0);

    // Timeout: busy_tx never rises
    apply_reset();
    mdl_en = 1'b0;
    req_if.req_data[7:0] = 8'h5A;
    req_if.req_last      = 4'b0001;
    req_if.req_valid     = 4'b0001;
    wait_shoot("tmo", ok);
    repeat (16) tick();
    check("tmo_early", 32'(err_tmo), 32'd0);
    tick();
    check("tmo_set_17", 32'(err_tmo),          32'd1);
    check("tmo_resched",32'(req_if.req_ready), 32'h1);
    tick();
    check("tmo_next_shoot", 32'(tx_shoot), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr          = 1'b0;
    req_if.req_valid = '0;
    check("tmo_clr", 32'(err_tmo), 32'd0);
    repeat (15) tick();
    err_clr = 1'b1;
    check("tmo_pre_same", 32'(err_tmo), 32'd0);
    tick();
    err_clr = 1'b0;
    check("tmo_set_wins", 32'(err_tmo), 32'd1);

    // Busy at idle, then rr_ptr wrap after a req3 packet
    apply_reset();
    busy_force = 1'b1;
    req_if.req_data  = {8'h3C, 8'h02, 8'h01, 8'h00};
    req_if.req_last  = 4'hF;
    req_if.req_valid = 4'b1000;
    rdy_seen = 1'b0;
    repeat (5) begin
      tick();
      if (req_if.req_ready != '0) rdy_seen = 1'b1;
    end
    check("bi_no_ready", 32'(rdy_seen), 32'd0);
    busy_force = 1'b0;
    mdl_en     = 1'b1;
    #1;
    check("bi_ready", 32'(req_if.req_ready), 32'h8);
    wait_shoot("bi3", ok);
    if (ok) begin
      check("bi_gnt3",  32'(grant_id), 32'd3);
      check("bi_data3", 32'(datatx),   32'h3C);
    end
    req_if.req_valid = 4'b0111;
    wait_shoot("biw", ok);
    if (ok) check("bi_wrap_gnt0", 32'(grant_id), 32'd0);
    req_if.req_valid = '0;

    // Async reset in the middle of a SHOOT cycle
    apply_reset();
    mdl_en = 1'b1;
    req_if.req_data[7:0] = 8'h99;
    req_if.req_last      = 4'b0000;
    req_if.req_valid     = 4'b0001;
    wait_shoot("ar", ok);
    check("ar_locked_pre", 32'(locked), 32'd1);
    #1;
    presetn = 1'b0;
    #1;
    check("ar_tx_shoot", 32'(tx_shoot), 32'd0);
    check("ar_locked",   32'(locked),   32'd0);
    check("ar_datatx",   32'(datatx),   32'd0);
    req_if.req_valid = '0;
    tick();
    presetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
